cpu_player_ctrl: RTL and testbench

- Computer opponent for the left court half.
- Acts as the stimulus end of the player interface: reads ball and own-player coordinates, and drives a 4-bit button vector with the same encoding the player movement block consumes.
- Output connects directly in place of the physical `usr_btn` of the left-side player instance.
- Decisions are made on a slow periodic tick. Jump presses are held long enough to pass the downstream debouncer.

---
 rtl/cpu_player_ctrl.sv | 125 ++++++++++++
 tb/tb_cpu_player_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_player_ctrl.sv
// cpu_player_ctrl: computer opponent for the left court half.
// Drives the player button vector from ball and own-player coordinates on a slow decision tick.
module cpu_player_ctrl #(
    parameter int PLAYER_W      = 41,
    parameter int FIELD_MIN_X   = 0,
    parameter int FIELD_MAX_X   = 159,
    parameter int GROUND_Y      = 178,
    parameter int DEAD_ZONE     = 4,
    parameter int JUMP_DX       = 12,
    parameter int JUMP_BALL_Y   = 120,
    parameter int DECIDE_PERIOD = 1048576,
    parameter int JUMP_HOLD     = 2097152,
    parameter int JUMP_COOLDOWN = 4194304
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  game_state,
    input  logic [11:0] ball_x,
    input  logic [11:0] ball_y,
    input  logic [11:0] player_x,
    input  logic [11:0] player_y,
    output logic [3:0]  btn
);
    localparam int TICK_W   = (DECIDE_PERIOD > 1) ? $clog2(DECIDE_PERIOD) : 1;
    localparam int HOLD_MAX = (JUMP_HOLD > JUMP_COOLDOWN) ? JUMP_HOLD : JUMP_COOLDOWN;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [1:0]         GS_PLAY = 2'd2;
    localparam logic signed [12:0] DZ      = 13'(DEAD_ZONE);
    localparam logic signed [12:0] JDX     = 13'(JUMP_DX);

    typedef enum logic [1:0] {IDLE, TRACK, JUMP_PRESS, JUMP_RELEASE} state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                right_q, right_d, left_q, left_d, jump_q, jump_d;

    logic signed [12:0]  err;
    logic [12:0]         right_edge;
    logic                playing, tick, want_right, want_left, jump_ok;

    assign playing    = (game_state == GS_PLAY);
    assign tick       = (tick_q == TICK_W'(DECIDE_PERIOD - 1));
    // Signed distance from the ball to the player's centre, both operands zero-extended.
    assign err        = $signed({1'b0, ball_x}) - $signed({1'b0, player_x} + 13'(PLAYER_W / 2));
    assign right_edge = {1'b0, player_x} + 13'(PLAYER_W - 1);

    assign want_right = (err > DZ) && (right_edge < 13'(FIELD_MAX_X));
    assign want_left  = (err < -DZ) && (player_x > 12'(FIELD_MIN_X));
    assign jump_ok    = (player_y == 12'(GROUND_Y)) && (err >= -JDX) && (err <= JDX)
                        && (ball_y >= 12'(JUMP_BALL_Y));

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d = state_q;
        tick_d  = tick_q;
        hold_d  = hold_q;
        right_d = right_q;
        left_d  = left_q;
        if (!playing) begin
            state_d = IDLE;
            tick_d  = '0;
            hold_d  = '0;
            right_d = 1'b0;
            left_d  = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = TRACK;
        end else begin
            tick_d = tick ? '0 : tick_q + TICK_W'(1);
            if (tick) begin
                right_d = want_right;
                left_d  = want_left;
            end
            unique case (state_q)
                TRACK: begin
                    if (tick && jump_ok) begin
                        state_d = JUMP_PRESS;
                        hold_d  = '0;
                    end
                end
                JUMP_PRESS: begin
                    if (hold_q == HOLD_W'(JUMP_HOLD - 1)) begin
                        state_d = JUMP_RELEASE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                JUMP_RELEASE: begin
                    if (hold_q == HOLD_W'(JUMP_COOLDOWN - 1)) begin
                        state_d = TRACK;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Jump is registered from the next state so btn never decodes live FSM bits.
    assign jump_d = (state_d == JUMP_PRESS);

    // NOTE: reset is synchronous; it is sampled only on the clock edge like any other input.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            hold_q  <= '0;
            right_q <= 1'b0;
            left_q  <= 1'b0;
            jump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            hold_q  <= hold_d;
            right_q <= right_d;
            left_q  <= left_d;
            jump_q  <= jump_d;
        end
    end

    assign btn = {1'b0, left_q, jump_q, right_q};
endmodule

// File: tb/tb_cpu_player_ctrl.sv
// Scoreboard bench for cpu_player_ctrl: a cycle-indexed reference model queues the expected
// btn for each clock edge and a negedge monitor pops and compares against the DUT.
module tb_cpu_player_ctrl;
    localparam int DP = 8;
    localparam int JH = 4;
    localparam int JC = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  game_state;
    logic [11:0] ball_x, ball_y, player_x, player_y;
    logic [3:0]  btn;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    cpu_player_ctrl #(
        .DECIDE_PERIOD(DP),
        .JUMP_HOLD    (JH),
        .JUMP_COOLDOWN(JC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .game_state(game_state),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .player_x  (player_x),
        .player_y  (player_y),
        .btn       (btn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: absolute cycle numbers and spec arithmetic on plain integers.
    int  t          = 0;
    int  n_play     = 0;
    bit  active     = 1'b0;
    bit  mv_r       = 1'b0;
    bit  mv_l       = 1'b0;
    int  press_end  = 0;
    int  busy_until = 0;

    always @(posedge clk) begin
        int e;
        t++;
        if (!reset_n || game_state != 2'd2) begin
            active = 1'b0; mv_r = 1'b0; mv_l = 1'b0; press_end = 0; busy_until = 0;
        end else if (!active) begin
            active = 1'b1;
            n_play = 0;
        end else begin
            n_play++;
            if (n_play % DP == 0) begin
                e    = int'(ball_x) - (int'(player_x) + 20);
                mv_r = (e > 4) && (int'(player_x) + 40 < 159);
                mv_l = (e < -4) && (int'(player_x) > 0);
                if (t >= busy_until && int'(player_y) == 178 && e >= -12 && e <= 12
                    && int'(ball_y) >= 120) begin
                    press_end  = t + JH;
                    busy_until = t + JH + JC + 1;
                end
            end
        end
        exp_q.push_back({1'b0, mv_l, (t < press_end), mv_r});
    end

    int  jump_rises  = 0;
    int  right_seen  = 0;
    int  left_seen   = 0;
    bit  prev_jump   = 1'b0;

    always @(negedge clk) begin
        logic [3:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow at %0t: got btn %b with no expected entry", $time, btn);
        end else begin
            exp = exp_q.pop_front();
            check("btn", {28'd0, btn}, {28'd0, exp});
        end
        if (btn[1] === 1'b1 && !prev_jump) jump_rises++;
        if (btn[0] === 1'b1) right_seen++;
        if (btn[2] === 1'b1) left_seen++;
        prev_jump = (btn[1] === 1'b1);
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_in(input logic [1:0] gs, input int bx, input int by, input int px,
                          input int py);
        game_state = gs;
        ball_x     = 12'(bx);
        ball_y     = 12'(by);
        player_x   = 12'(px);
        player_y   = 12'(py);
    endtask

    initial begin
        bit seen;
        int px, bx, off;

        reset_n = 1'b0;
        set_in(2'd2, 81, 50, 60, 100);
        cycles(3);
        reset_n = 1'b1;
        cycles(20);                           // e = 1: inside dead zone

        set_in(2'd2, 100, 50, 10, 100);       // airborne, far right of player
        cycles(12);
        set_in(2'd2, 150, 50, 119, 100);      // right edge at field limit
        cycles(10);

        set_in(2'd2, 20, 50, 100, 100);       // ball to the left
        cycles(10);
        set_in(2'd2, 5, 50, 0, 100);          // already at left limit
        cycles(10);

        set_in(2'd2, 75, 130, 50, 178);       // jump conditions held
        cycles(40);

        set_in(2'd2, 75, 100, 50, 178);       // ball too high
        cycles(20);
        set_in(2'd2, 83, 130, 50, 178);       // e = 13, outside jump window
        cycles(20);

        // Abort play during the second cycle of a press.
        set_in(2'd2, 75, 130, 50, 178);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cycles(1);
            if (btn[1] === 1'b1) seen = 1'b1;
        end
        check("jump_rise_before_abort", {31'd0, seen}, 32'd1);
        cycles(1);
        game_state = 2'd1;
        cycles(3);
        game_state = 2'd2;
        cycles(24);

        // Randomised segments biased toward jump opportunities.
        for (int s = 0; s < 250; s++) begin
            px  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 140))
                                              : int'($urandom_range(0, 118));
            off = int'($urandom_range(0, 32)) - 16;
            bx  = ($urandom_range(0, 9) < 6) ? px + 20 + off : int'($urandom_range(0, 200));
            if (bx < 0) bx = 0;
            set_in(($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'd2,
                   bx,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 119))
                                               : int'($urandom_range(120, 239)),
                   px,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 177)) : 178);
            reset_n = ($urandom_range(0, 39) != 0);
            cycles(int'($urandom_range(1, 30)));
        end

        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("jump_pulses_seen", {31'd0, jump_rises > 0}, 32'd1);
        check("right_moves_seen", {31'd0, right_seen > 0}, 32'd1);
        check("left_moves_seen", {31'd0, left_seen > 0}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
